// File: rtl/multi_sync_filter.sv
// Per-channel level synchroniser: STAGES-deep flop chain followed by a FILT_LEN consecutive-cycle glitch filter.
// Define SYNC_EDGE_DET_EN to build registered o_rise/o_fall pulses; otherwise they are tied to 0.
module multi_sync_filter #(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 2,
    parameter int               FILT_LEN = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    localparam int CNT_W = (FILT_LEN < 1) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("multi_sync_filter: STAGES must be >= 2");
        end
        if (FILT_LEN < 1) begin : g_bad_filt_len
            $error("multi_sync_filter: FILT_LEN must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] sync_chain [STAGES];
    logic [WIDTH-1:0] s_level;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] accept;

    // Synchroniser chain: nothing but flops between the pin and s_level.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_chain[k] <= RST_VAL;
            end
        end else begin
            sync_chain[0] <= i_async;
            for (int k = 1; k < STAGES; k++) begin
                sync_chain[k] <= sync_chain[k-1];
            end
        end
    end

    assign s_level = sync_chain[STAGES-1];

    // A channel commits its new level on the FILT_LEN-th consecutive disagreeing cycle.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s_level[i] != o_sync[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_sync <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s_level[i] == o_sync[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    o_sync[i] <= s_level[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef SYNC_EDGE_DET_EN
    // Pulses share the edge that updates o_sync, so they line up with the new level.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_rise <= '0;
            o_fall <= '0;
        end else begin
            o_rise <= accept & s_level;
            o_fall <= accept & ~s_level;
        end
    end
`else
    assign o_rise = '0;
    assign o_fall = '0;
`endif

endmodule

// File: tb/tb_multi_sync_filter.sv
// Bench for multi_sync_filter: three configurations checked against a window-based reference model,
// plus a constant-expectation vector table and directed corner-case sequences.
module tb_multi_sync_filter;

`ifdef SYNC_EDGE_DET_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] a_in, a_sync, a_rise, a_fall;
    logic [0:0] b_in, b_sync, b_rise, b_fall;
    logic [3:0] c_in, c_sync, c_rise, c_fall;

    multi_sync_filter #(.WIDTH(4), .STAGES(2), .FILT_LEN(4), .RST_VAL(4'b0000)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_async(a_in),
        .o_sync(a_sync), .o_rise(a_rise), .o_fall(a_fall));

    multi_sync_filter #(.WIDTH(1), .STAGES(3), .FILT_LEN(1), .RST_VAL(1'b0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_async(b_in),
        .o_sync(b_sync), .o_rise(b_rise), .o_fall(b_fall));

    multi_sync_filter #(.WIDTH(4), .STAGES(3), .FILT_LEN(3), .RST_VAL(4'b1010)) dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_async(c_in),
        .o_sync(c_sync), .o_rise(c_rise), .o_fall(c_fall));

    // Reference: the filter sees the input captured STAGES edges earlier; a bit adopts value v
    // once the last FILT_LEN seen samples (since reset) are all v and v differs from the output.
    typedef struct packed {
        logic [7:0][3:0] pipe;
        logic [7:0][3:0] hist;
        logic [3:0]      nvalid;
        logic [3:0]      out;
        logic [3:0]      rise;
        logic [3:0]      fall;
    } model_t;

    function automatic model_t model_step(model_t m, int stages, int filt,
                                          logic [3:0] rstv, logic [3:0] din, logic rn);
        model_t     n = m;
        logic [3:0] s;
        bit         agree;
        if (!rn) begin
            for (int k = 0; k < 8; k++) n.pipe[k] = rstv;
            n.hist   = '0;
            n.nvalid = '0;
            n.out    = rstv;
            n.rise   = '0;
            n.fall   = '0;
            return n;
        end
        s = m.pipe[stages-1];
        for (int k = 7; k > 0; k--) n.hist[k] = m.hist[k-1];
        n.hist[0] = s;
        if (m.nvalid < 4'd8) n.nvalid = m.nvalid + 4'd1;
        n.rise = '0;
        n.fall = '0;
        for (int b = 0; b < 4; b++) begin
            agree = (int'(n.nvalid) >= filt);
            for (int k = 0; k < filt; k++) begin
                if (n.hist[k][b] != s[b]) agree = 1'b0;
            end
            if (agree && (s[b] != m.out[b])) begin
                n.out[b] = s[b];
                if (EDGE_EN) begin
                    n.rise[b] = s[b];
                    n.fall[b] = ~s[b];
                end
            end
        end
        for (int k = 7; k > 0; k--) n.pipe[k] = m.pipe[k-1];
        n.pipe[0] = din;
        return n;
    endfunction

    model_t     ma, mb, mc;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] rise_acc, fall_acc;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // One clock edge: advance the models with the inputs present at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        ma = model_step(ma, 2, 4, 4'b0000, a_in, rst_n);
        mb = model_step(mb, 3, 1, 4'b0000, {3'b000, b_in}, rst_n);
        mc = model_step(mc, 3, 3, 4'b1010, c_in, rst_n);
        cyc++;
        #1;
        check("a_sync", a_sync, ma.out);
        check("a_rise", a_rise, ma.rise);
        check("a_fall", a_fall, ma.fall);
        check("b_sync", {3'b000, b_sync}, mb.out & 4'b0001);
        check("b_rise", {3'b000, b_rise}, mb.rise & 4'b0001);
        check("b_fall", {3'b000, b_fall}, mb.fall & 4'b0001);
        check("c_sync", c_sync, mc.out);
        check("c_rise", c_rise, mc.rise);
        check("c_fall", c_fall, mc.fall);
        rise_acc |= a_rise;
        fall_acc |= a_fall;
    endtask

    typedef struct {
        logic       rn;
        logic [3:0] a;
        logic [3:0] exp_sync;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
    } vec_t;

    vec_t tbl [$];
    logic bh [64];

    initial begin
        // Edge k of the table is row k-1. Reset with input high, capture 0->1 at edge 10,
        // expect o_sync at edge 15, reject a 3-cycle low glitch, then fall at edge 33.
        for (int e = 1; e <= 3; e++)   tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 4'h0});
        for (int e = 4; e <= 9; e++)   tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'h0});
        for (int e = 10; e <= 14; e++) tbl.push_back('{1'b1, 4'h1, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'h1, 4'h1, EDGE_EN ? 4'h1 : 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'h1, 4'h1, 4'h0, 4'h0});
        for (int e = 17; e <= 19; e++) tbl.push_back('{1'b1, 4'h0, 4'h1, 4'h0, 4'h0});
        for (int e = 20; e <= 27; e++) tbl.push_back('{1'b1, 4'h1, 4'h1, 4'h0, 4'h0});
        for (int e = 28; e <= 32; e++) tbl.push_back('{1'b1, 4'h0, 4'h1, 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, EDGE_EN ? 4'h1 : 4'h0});

        rst_n = 1'b0;
        a_in = 4'h0;
        b_in = 1'b0;
        c_in = 4'hF;
        ma = '0;
        mb = '0;
        mc = '0;
        rise_acc = '0;
        fall_acc = '0;

        foreach (tbl[i]) begin
            rst_n = tbl[i].rn;
            a_in  = tbl[i].a;
            cycle();
            check("tbl_sync", a_sync, tbl[i].exp_sync);
            check("tbl_rise", a_rise, tbl[i].exp_rise);
            check("tbl_fall", a_fall, tbl[i].exp_fall);
        end

        // Glitch reject from a settled 0: three high cycles never reach o_sync.
        a_in = 4'h0;
        repeat (4) cycle();
        rise_acc = '0;
        fall_acc = '0;
        a_in = 4'h1;
        repeat (3) cycle();
        a_in = 4'h0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("glitch_sync", a_sync, 4'h0);
        end
        check("glitch_rise", rise_acc, 4'h0);
        check("glitch_fall", fall_acc, 4'h0);

        // Mid-filter reset: two counts accumulated, then reset; a full persistence is needed again.
        a_in = 4'h1;
        repeat (4) cycle();
        check("mid_pre", a_sync, 4'h0);
        rst_n = 1'b0;
        cycle();
        check("mid_rst", a_sync, 4'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("mid_after", a_sync, (k == 6) ? 4'h1 : 4'h0);
        end

        // Channel independence: bit 0 glitches low for 2 cycles while bit 2 toggles.
        repeat (3) cycle();
        rise_acc = '0;
        fall_acc = '0;
        a_in = 4'b0100;
        repeat (2) cycle();
        a_in = 4'b0101;
        repeat (8) cycle();
        check("ind_high", a_sync, 4'b0101);
        a_in = 4'b0001;
        repeat (8) cycle();
        check("ind_low", a_sync, 4'b0001);
        check("ind_rise", rise_acc, EDGE_EN ? 4'b0100 : 4'b0000);
        check("ind_fall", fall_acc, EDGE_EN ? 4'b0100 : 4'b0000);

        // Bypass instance: period-4 square wave reproduced three edges later.
        for (int k = 0; k < 32; k++) begin
            b_in  = (k % 4) < 2;
            bh[k] = b_in;
            cycle();
            if (k >= 3) check("bypass", {3'b000, b_sync}, {3'b000, bh[k-3]});
        end

        // Random phase: sticky inputs with occasional bit flips and rare resets.
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) a_in[b] = ~a_in[b];
                if ($urandom_range(0, 3) == 0) c_in[b] = ~c_in[b];
            end
            if ($urandom_range(0, 2) == 0) b_in = ~b_in;
            rst_n = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
